// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: data width, default imem depth, fetch FSM states
// and the fetch buffer entry layout.
package cpu_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned IMEM_WORDS_DEF = 32;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // True when a word address lies inside an instruction memory of 'words' entries.
  function automatic logic pc_in_range(input logic [XLEN-1:0] pc, input int unsigned words);
    return pc < XLEN'(words);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous fetch buffer: push/pop/flush, power-of-2 depth, zeroed storage on
// reset so the head never reads as X.
module ifetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head_c,
  output logic         full_c,
  output logic         empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch initiator: word-addressed imem fetch, buffered handoff to
// decode, redirect/halt/out-of-range handling. IFETCH_PERF_EN adds perf counters.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_oob
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_flushes
`endif
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  fetch_pc_d;
  logic         oob_q;
  logic         oob_d;
  fetch_entry_t last_q;
  fetch_entry_t head;
  fetch_entry_t wr_entry;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pc_legal;
  logic         redir_legal;
  logic         fetch_en;
  logic         push;
  logic         pop;

  assign pc_legal    = pc_in_range(fetch_pc_q, IMEM_WORDS);
  assign redir_legal = pc_in_range(redirect_pc, IMEM_WORDS);
  assign pop         = !fifo_empty && id_ready;
  assign fetch_en    = (state_q == S_RUN) && !halt && pc_legal;
  // The word on idata is dropped when a redirect lands in the same cycle.
  assign push        = fetch_en && (!fifo_full || pop) && !redirect_valid;
  assign wr_entry    = '{pc: fetch_pc_q, instr: idata};

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .head_c   (head),
    .full_c   (fifo_full),
    .empty_c  (fifo_empty)
  );

  // Next-state: redirect overrides everything; out-of-range detection only in S_RUN.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    oob_d      = oob_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      if (redir_legal) begin
        oob_d = 1'b0;
      end
      state_d = halt ? S_HALT : S_RUN;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd1;
      end
      case (state_q)
        S_RUN: begin
          if (!pc_legal) begin
            state_d = S_HALT;
            oob_d   = 1'b1;
          end else if (halt) begin
            state_d = S_HALT;
          end
        end
        S_HALT: begin
          if (!halt && !oob_q) begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      fetch_pc_q <= 32'(RESET_PC);
      oob_q      <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      oob_q      <= oob_d;
      if (!fifo_empty) begin
        last_q <= head;
      end
    end
  end

  // Head fields hold the last delivered entry while the buffer is empty.
  assign iaddr     = fetch_pc_q;
  assign if_valid  = !fifo_empty;
  assign if_instr  = fifo_empty ? last_q.instr : head.instr;
  assign if_pc     = fifo_empty ? last_q.pc : head.pc;
  assign fetch_oob = oob_q;

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetches <= '0;
      perf_flushes <= '0;
    end else begin
      if (push) begin
        perf_fetches <= perf_fetches + 32'd1;
      end
      if (redirect_valid) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed-vector bench for ifetch_unit with an imem model m[k] = k + 0x100.
// Define IFETCH_PERF_EN for both files to also exercise the perf counters.
module tb_ifetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_oob;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_flushes;
`endif

  int n_vec;
  int n_err;

  ifetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .iaddr          (iaddr),
    .idata          (idata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_oob      (fetch_oob)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetches   (perf_fetches),
    .perf_flushes   (perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb idata = iaddr + 32'h100;

  typedef struct {
    logic        r;
    logic        y;
    logic        rv;
    logic [31:0] rpc;
    logic        h;
    logic        chk;
    logic        v;
    logic [31:0] epc;
    logic [31:0] ei;
    logic [31:0] ea;
    logic        eo;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, y, rv, input logic [31:0] rpc, input logic h,
                     input logic chk, v, input logic [31:0] epc, ei, ea, input logic eo);
    vec_t t;
    t = '{r: r, y: y, rv: rv, rpc: rpc, h: h, chk: chk, v: v, epc: epc, ei: ei, ea: ea, eo: eo};
    tv.push_back(t);
  endtask

  task automatic cmp(input string nm, input int row, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h, expected %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, y, rv, input logic [31:0] rpc, input logic h);
    reset          = r;
    id_ready       = y;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int exp_next;
  int waited;

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

    //   r  y  rv rpc  h  chk v  epc  instr     iaddr oob
    add(1, 0, 0, 0,  0, 0,  0, 0,   32'h0,    0,  0);
    // streaming with decode always ready
    add(0, 1, 0, 0,  0, 1,  0, 0,   32'h0,    0,  0);
    add(0, 1, 0, 0,  0, 1,  1, 0,   32'h100,  1,  0);
    add(0, 1, 0, 0,  0, 1,  1, 1,   32'h101,  2,  0);
    add(0, 1, 0, 0,  0, 1,  1, 2,   32'h102,  3,  0);
    // mid-stream reset, then 5 cycles of backpressure
    add(1, 0, 0, 0,  0, 1,  1, 3,   32'h103,  4,  0);
    add(0, 0, 0, 0,  0, 1,  0, 0,   32'h0,    0,  0);
    add(0, 0, 0, 0,  0, 1,  1, 0,   32'h100,  1,  0);
    add(0, 0, 0, 0,  0, 1,  1, 0,   32'h100,  2,  0);
    add(0, 0, 0, 0,  0, 1,  1, 0,   32'h100,  2,  0);
    add(0, 0, 0, 0,  0, 1,  1, 0,   32'h100,  2,  0);
    add(0, 1, 0, 0,  0, 1,  1, 0,   32'h100,  2,  0);
    add(0, 1, 0, 0,  0, 1,  1, 1,   32'h101,  3,  0);
    add(0, 1, 0, 0,  0, 1,  1, 2,   32'h102,  4,  0);
    // redirect at fetch_pc=5 to 20
    add(0, 1, 1, 20, 0, 1,  1, 3,   32'h103,  5,  0);
    add(0, 1, 0, 0,  0, 1,  0, 3,   32'h103,  20, 0);
    add(0, 1, 0, 0,  0, 1,  1, 20,  32'h114,  21, 0);
    add(0, 1, 0, 0,  0, 1,  1, 21,  32'h115,  22, 0);
    // reset, fill, halt at fetch_pc=4 for 3 cycles
    add(1, 1, 0, 0,  0, 1,  1, 22,  32'h116,  23, 0);
    add(0, 1, 0, 0,  0, 1,  0, 0,   32'h0,    0,  0);
    add(0, 1, 0, 0,  0, 1,  1, 0,   32'h100,  1,  0);
    add(0, 1, 0, 0,  0, 1,  1, 1,   32'h101,  2,  0);
    add(0, 0, 0, 0,  0, 1,  1, 2,   32'h102,  3,  0);
    add(0, 1, 0, 0,  1, 1,  1, 2,   32'h102,  4,  0);
    add(0, 1, 0, 0,  1, 1,  1, 3,   32'h103,  4,  0);
    add(0, 1, 0, 0,  1, 1,  0, 3,   32'h103,  4,  0);
    add(0, 1, 0, 0,  0, 1,  0, 3,   32'h103,  4,  0);
    add(0, 1, 0, 0,  0, 1,  0, 3,   32'h103,  4,  0);
    add(0, 1, 0, 0,  0, 1,  1, 4,   32'h104,  5,  0);
    add(0, 1, 0, 0,  0, 1,  1, 5,   32'h105,  6,  0);
    // run off the end of imem, then redirect to 0
    add(0, 1, 1, 29, 0, 1,  1, 6,   32'h106,  7,  0);
    add(0, 1, 0, 0,  0, 1,  0, 6,   32'h106,  29, 0);
    add(0, 1, 0, 0,  0, 1,  1, 29,  32'h11D,  30, 0);
    add(0, 1, 0, 0,  0, 1,  1, 30,  32'h11E,  31, 0);
    add(0, 1, 0, 0,  0, 1,  1, 31,  32'h11F,  32, 0);
    add(0, 1, 0, 0,  0, 1,  0, 31,  32'h11F,  32, 1);
    add(0, 1, 0, 0,  0, 1,  0, 31,  32'h11F,  32, 1);
    add(0, 1, 1, 0,  0, 1,  0, 31,  32'h11F,  32, 1);
    add(0, 1, 0, 0,  0, 1,  0, 31,  32'h11F,  0,  0);
    add(0, 1, 0, 0,  0, 1,  1, 0,   32'h100,  1,  0);
    // redirect out of range, then redirect while halted
    add(0, 1, 1, 40, 0, 1,  1, 1,   32'h101,  2,  0);
    add(0, 1, 0, 0,  0, 1,  0, 1,   32'h101,  40, 0);
    add(0, 1, 0, 0,  0, 1,  0, 1,   32'h101,  40, 1);
    add(0, 1, 1, 10, 1, 1,  0, 1,   32'h101,  40, 1);
    add(0, 1, 0, 0,  1, 1,  0, 1,   32'h101,  10, 0);
    add(0, 1, 0, 0,  0, 1,  0, 1,   32'h101,  10, 0);
    add(0, 1, 0, 0,  0, 1,  0, 1,   32'h101,  10, 0);
    add(0, 1, 0, 0,  0, 1,  1, 10,  32'h10A,  11, 0);

    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].y, tv[i].rv, tv[i].rpc, tv[i].h);
      @(negedge clk);
      if (tv[i].chk) begin
        cmp("if_valid",  i, 32'(if_valid),  32'(tv[i].v));
        cmp("if_pc",     i, if_pc,          tv[i].epc);
        cmp("if_instr",  i, if_instr,       tv[i].ei);
        cmp("iaddr",     i, iaddr,          tv[i].ea);
        cmp("fetch_oob", i, 32'(fetch_oob), 32'(tv[i].eo));
      end
      next_cycle();
    end

    // In-order delivery under an irregular ready pattern.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    waited = 0;
    while (!if_valid && waited < 4) begin
      next_cycle();
      waited++;
    end
    cmp("first_valid_timeout", 0, 32'(if_valid), 32'd1);
    exp_next = 0;
    for (int c = 0; c < 40; c++) begin
      id_ready = ((c % 3) != 0);
      @(negedge clk);
      if (if_valid && id_ready) begin
        cmp("seq_pc",    c, if_pc,    32'(exp_next));
        cmp("seq_instr", c, if_instr, 32'(exp_next) + 32'h100);
        exp_next++;
      end
      next_cycle();
    end
    cmp("seq_delivered_enough", 0, 32'(exp_next >= 20), 32'd1);

`ifdef IFETCH_PERF_EN
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    cmp("perf_fetches_rst", 0, perf_fetches, 32'd0);
    cmp("perf_flushes_rst", 0, perf_flushes, 32'd0);
    for (int c = 0; c < 6; c++) next_cycle();
    drive(1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int c = 0; c < 4; c++) next_cycle();
    drive(1'b0, 1'b1, 1'b1, 32'd3, 1'b1);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    next_cycle();
    @(negedge clk);
    cmp("perf_fetches", 0, perf_fetches, 32'd10);
    cmp("perf_flushes", 0, perf_flushes, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
